led_stretch: RTL
================

# led_stretch

Output-side companion to the input debouncer: it drives a physical indicator (LED or lamp) from fabric events. Fabric pulses, which may be a single clock cycle long, are stretched to a human-visible minimum on-time. A level request produces a fixed-rate blink. It sits between the traffic-light controller logic and the board output pins.

## Interface
Parameters:
- C_CLK_FRQ, 100_000_000, clock frequency [Hz].
- C_HOLD_MS, 50, minimum on-time per pulse [ms], integer ≥ 1.
- C_BLINK_MS, 250, blink half-period (on time = off time) [ms], integer ≥ 1.

Derived:
- C_HOLD_CYC = C_CLK_FRQ*C_HOLD_MS/1000.
- C_BLINK_CYC = C_CLK_FRQ*C_BLINK_MS/1000.
- Both must be ≥ 1.
- Counter width = $clog2(max(C_HOLD_CYC, C_BLINK_CYC)+1).

Ports:
- clk  in  1  master clock.
- rstb  in  1  reset rstb, synchronous, active-low; clock clk.
- pulse  in  1  fabric event, sampled every cycle; any high cycle triggers or retriggers the hold.
- blink  in  1  level request; while high, the output blinks.
- led  out  1  registered drive to pin, active high.
- busy  out  1  registered, high whenever state ≠ IDLE.

## Operation
- States: IDLE, HOLD, BLINK_ON, BLINK_OFF. One down/up counter, cnt.
- Input priority in every state: blink=1 > pulse=1 > none.
- IDLE (led=0):
  - blink=1 → BLINK_ON, cnt=0.
  - else pulse=1 → HOLD, cnt=0.
  - else stay.
- HOLD (led=1):
  - blink=1 → BLINK_ON, cnt=0.
  - else pulse=1 → stay in HOLD, cnt=0 (retrigger).
  - else cnt==C_HOLD_CYC-1 → IDLE.
  - else cnt+1.
- BLINK_ON (led=1) / BLINK_OFF (led=0):
  - blink=0 and pulse=1 → HOLD, cnt=0.
  - blink=0 and pulse=0 → IDLE.
  - else cnt==C_BLINK_CYC-1 → switch to the other blink phase, cnt=0.
  - else cnt+1.
- Pulses received while blink=1 are ignored and not remembered.
- led and busy are decoded from the next state and registered. They change on the same edge as the state.
- cnt never exceeds its terminal value. There is no wrap-around.
- Reset: state=IDLE, cnt=0, led=0, busy=0 on the first clk edge with rstb=0. This holds from any state, mid-hold or mid-blink. Inputs are ignored while rstb=0.

## Timing
- Pulse high at edge N (from IDLE) → led=1 and busy=1 during cycles N+1 … N+C_HOLD_CYC.
  - led=0 and busy=0 from N+C_HOLD_CYC+1.
  - Exactly C_HOLD_CYC high cycles.
- Retrigger at edge M during HOLD → led stays high through M+C_HOLD_CYC with no low glitch.
- Continuous pulse=1 → led stays high until C_HOLD_CYC cycles after the last high sample.
- Blink high at edge N → led high N+1 … N+C_BLINK_CYC, low for the next C_BLINK_CYC cycles, and repeats.
  - Period = 2·C_BLINK_CYC. The first phase is always ON, including entry from HOLD.
- Blink low at edge M → led=0 and busy=0 at M+1. The exception is pulse=1 at M: then HOLD is entered and led=1 at M+1 for C_HOLD_CYC cycles.
- C_HOLD_CYC=1: a single pulse gives exactly one led-high cycle.
- Latency from input to output is always 1 clk. There are no combinational paths from input to output.

## Test plan
Bench parameters: C_CLK_FRQ=1000, C_HOLD_MS=4, C_BLINK_MS=3, so C_HOLD_CYC=4 and C_BLINK_CYC=3.

- Single pulse: one-cycle pulse at cycle 10 → led=1 and busy=1 on cycles 11–14, both 0 at cycle 15.
- Retrigger: pulses at cycles 10 and 12 → led high on cycles 11–16 continuously, low at cycle 17.
- Blink: blink high from cycle 20 to cycle 34 → led pattern from cycle 21 is 1,1,1,0,0,0,1,1,1,0,0,0,1,1. led=0 and busy=0 at cycle 35.
- Priority: pulse at 10, blink rises at 12 → led stays 1 through 15, then 0 on 16–18. Pulses applied during blink have no effect.
- Exit-to-hold: blink falls while pulse=1 at the same edge M (in BLINK_OFF) → led=1 on M+1 … M+4, then 0.
- Reset mid-operation: rstb=0 for one cycle in HOLD or in BLINK_ON → led=0, busy=0 on the next cycle. With no further stimulus, both stay 0. A pulse applied during reset produces no output.

Source files
------------

// File: rtl/led_stretch_if.sv
// Indicator-side signal bundle: fabric event/blink requests in, registered pin drive out.
interface led_stretch_if;
  logic pulse;
  logic blink;
  logic led;
  logic busy;

  modport master (output pulse, output blink, input led, input busy);
  modport slave  (input pulse, input blink, output led, output busy);
endinterface

// File: rtl/led_stretch.sv
// Stretches fabric pulses to a visible minimum on-time and blinks the indicator
// at a fixed rate while a level request is held.
module led_stretch #(
  parameter int C_CLK_FRQ  = 100_000_000,
  parameter int C_HOLD_MS  = 50,
  parameter int C_BLINK_MS = 250
) (
  input  logic          clk,
  input  logic          rstb,
  led_stretch_if.slave  bus
);
  // 64-bit math: frequency * milliseconds overflows 32 bits at realistic clocks
  localparam longint C_HOLD_CYC  = longint'(C_CLK_FRQ) * C_HOLD_MS  / 1000;
  localparam longint C_BLINK_CYC = longint'(C_CLK_FRQ) * C_BLINK_MS / 1000;
  localparam longint C_MAX_CYC   = (C_HOLD_CYC > C_BLINK_CYC) ? C_HOLD_CYC : C_BLINK_CYC;
  localparam int     CW          = $clog2(C_MAX_CYC + 1);
  localparam logic [CW-1:0] HOLD_TC  = CW'(C_HOLD_CYC - 1);
  localparam logic [CW-1:0] BLINK_TC = CW'(C_BLINK_CYC - 1);

  typedef enum logic [1:0] {IDLE, HOLD, BLINK_ON, BLINK_OFF} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            led_q, led_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.blink) begin
          state_d = BLINK_ON;
          cnt_d   = '0;
        end else if (bus.pulse) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (bus.blink) begin
          state_d = BLINK_ON;
          cnt_d   = '0;
        end else if (bus.pulse) begin
          cnt_d   = '0;
        end else if (cnt_q == HOLD_TC) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      BLINK_ON, BLINK_OFF: begin
        // Pulses during blink are dropped; only the exit edge can enter HOLD
        if (!bus.blink) begin
          state_d = bus.pulse ? HOLD : IDLE;
          cnt_d   = '0;
        end else if (cnt_q == BLINK_TC) begin
          state_d = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    led_d  = (state_d == HOLD) || (state_d == BLINK_ON);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.busy = busy_q;
endmodule
